// File: rtl/skid_pkg.sv
// skid_pkg: shared state type and encodings for skid_register.
package skid_pkg;
  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;
  typedef enum logic [1:0] {
    EMPTY = ST_EMPTY,
    BUSY = ST_BUSY,
    FULL = ST_FULL
  } state_t;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/skid_register.sv
// skid_register: fully registered two-entry skid buffer; SKID_REGISTER_STATS_EN adds stall/xfer counters.
module skid_register
  import skid_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data
`ifdef SKID_REGISTER_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] xfer_count
`endif
);
  state_t state, state_n;
  logic [WIDTH-1:0] skid;
  logic in_xfer, out_xfer;
  always_comb begin
    in_xfer = in_valid & in_ready;
    out_xfer = out_valid & out_ready;
    state_n = state == EMPTY ? (in_xfer ? BUSY : EMPTY) :
              state == BUSY  ? (in_xfer && !out_xfer ? FULL : !in_xfer && out_xfer ? EMPTY : BUSY) :
                               (out_xfer ? BUSY : FULL);
  end
  // handshake outputs are precomputed from the next state so they come straight from flops
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= EMPTY;
      out_valid <= 1'b0;
      in_ready <= 1'b0;
      out_data <= '0;
      skid <= '0;
    end else begin
      state <= state_n;
      out_valid <= state_n != EMPTY;
      in_ready <= state_n != FULL;
      if (state == FULL && out_xfer) out_data <= skid;
      else if (in_xfer && (state == EMPTY || out_xfer)) out_data <= in_data;
      if (state == BUSY && in_xfer && !out_xfer) skid <= in_data;
    end
`ifdef SKID_REGISTER_STATS_EN
  sat_counter #(.WIDTH(CNT_WIDTH)) u_stall (.clk, .rst, .inc(out_valid & ~out_ready), .count(stall_count));
  sat_counter #(.WIDTH(CNT_WIDTH)) u_xfer (.clk, .rst, .inc(out_xfer), .count(xfer_count));
`else
  logic [CNT_WIDTH-1:0] unused_cnt;
  assign unused_cnt = '0;
`endif
endmodule
